// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
// Assembles big-endian words, writes them to imem and releases cpu_reset once the XOR checksum matches.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_e;

  localparam logic [31:0]     MAX_WORDS = 32'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic              hdr_bad;
  logic [ADDR_W:0]   word_cnt_inc;

  assign rx_ready     = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept       = rx_valid & rx_ready;
  assign hdr_bad      = (rx_data == 8'd0) || (32'(rx_data) > MAX_WORDS);
  assign word_cnt_inc = word_cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;

    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_DATA;
            n_d        = (ADDR_W+1)'(rx_data);
            word_cnt_d = '0;
            byte_cnt_d = '0;
            acc_d      = rx_data;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d      = {asm_q[15:0], rx_data};
          acc_d      = acc_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wd_d       = {asm_q, rx_data};
            word_cnt_d = word_cnt_inc;
            if (word_cnt_inc == n_q) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    // Status outputs follow the state being entered so they settle on the same edge.
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HDR;
      n_q         <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      acc_q       <= '0;
      asm_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      asm_q       <= asm_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
// Expected writes and status come from an image-level model of the stream format.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_wq[$];
  wr_t         mon_w;
  logic [31:0] words[$];
  logic [7:0]  s[$];
  logic [7:0]  s_part[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we !== 1'b0) begin
      if (exp_wq.size() == 0) begin
        check_eq("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_wq.pop_front();
        check_eq("wr_addr", 32'(imem_addr), mon_w.addr);
        check_eq("wr_data", imem_wd, mon_w.data);
      end
    end
  end

  task automatic build(input logic [31:0] w[$], input bit bad, output logic [7:0] q[$]);
    logic [7:0] x;
    q = {};
    x = 8'(w.size());
    q.push_back(x);
    foreach (w[i]) begin
      for (int b = 3; b >= 0; b--) begin
        q.push_back(w[i][8*b +: 8]);
        x = x ^ w[i][8*b +: 8];
      end
    end
    q.push_back(bad ? ~x : x);
  endtask

  task automatic expect_writes(input logic [31:0] w[$]);
    foreach (w[i]) exp_wq.push_back('{addr: 32'(i), data: w[i]});
  endtask

  task automatic rand_words(input int n, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back($urandom);
  endtask

  // Entered and left at a negedge; the byte is accepted on the posedge in between.
  task automatic send_stream(input logic [7:0] q[$], input int gap_max);
    int hn;
    bit hv;
    hn = int'(q[0]);
    hv = (hn != 0) && (hn <= DEPTH);
    foreach (q[i]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = q[i];
      check_eq("rx_ready_for_byte", 32'(rx_ready), 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
      if (hv && i >= 1 && i <= 4*hn && (i % 4) == 0)
        check_eq("we_one_cycle_after_word", 32'(imem_we), 32'd1);
    end
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit c, input bit r);
    check_eq({tag, "_done"},      32'(done),      32'(d));
    check_eq({tag, "_error"},     32'(error),     32'(e));
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    check_eq({tag, "_rx_ready"},  32'(rx_ready),  32'(r));
    check_eq({tag, "_writes_left"}, 32'(exp_wq.size()), 32'd0);
  endtask

  task automatic pulse_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_error"},     32'(error),     32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rx_ready"},  32'(rx_ready),  32'd1);
    check_eq({tag, "_imem_we"},   32'(imem_we),   32'd0);
    check_eq({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check_eq({tag, "_imem_wd"},   imem_wd,        32'd0);
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_error"},     32'(error),     32'd0);
  endtask

  initial begin
    bit bad;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge clk);

    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    words = '{32'h12345678, 32'h9ABCDEF0};
    expect_writes(words);
    send_stream(s, 0);
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);

    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check_status("done_ignores_rx", 1'b1, 1'b0, 1'b0, 1'b0);

    pulse_reload("reload1");
    s[9] = 8'h03;
    expect_writes(words);
    send_stream(s, 0);
    check_status("bad_chk", 1'b0, 1'b1, 1'b1, 1'b0);

    pulse_reload("reload2");
    send_stream('{8'h00}, 0);
    check_status("hdr_00", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_reload("reload3");
    send_stream('{8'h41}, 0);
    check_status("hdr_41", 1'b0, 1'b1, 1'b1, 1'b0);

    pulse_reload("reload4");
    rand_words(DEPTH, words);
    build(words, 1'b0, s);
    expect_writes(words);
    send_stream(s, 3);
    check_status("full_64", 1'b1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      pulse_reload("reload_rand");
      rand_words($urandom_range(16, 1), words);
      bad = 1'($urandom_range(1, 0));
      build(words, bad, s);
      expect_writes(words);
      send_stream(s, 2);
      check_status(bad ? "rand_bad" : "rand_good", !bad, bad, bad, 1'b0);
    end

    pulse_reload("reload5");
    rand_words(2, words);
    build(words, 1'b0, s);
    s_part = s[0:6];
    exp_wq.push_back('{addr: 32'd0, data: words[0]});
    send_stream(s_part, 0);
    reset = 1'b1;
    #1;
    check_reset_values("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rand_words(1, words);
    build(words, 1'b0, s);
    expect_writes(words);
    send_stream(s, 1);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    pulse_reload("reload6");
    words = '{32'hA5A5_0F0F ^ words[0]};
    build(words, 1'b0, s);
    expect_writes(words);
    send_stream(s, 1);
    check_status("overwrite", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
